// File: rtl/ack_nak_gen.sv
// Receive-side ACK/NAK generator: classifies checked TLPs against NEXT_RCV_SEQ
// and issues coalesced ACK or NAK DLLP requests to the TX DLLP arbiter.
module ack_nak_gen #(
  parameter int ACK_LAT      = 64,
  parameter int ACK_COALESCE = 4,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlp_done,
  input  logic [11:0] tlp_seq,
  input  logic        lcrc_ok,
  output logic        tlp_accept,
  output logic        tlp_discard,
  output logic        dllp_valid,
  input  logic        dllp_ready,
  output logic [1:0]  dllp_ack_nack,
  output logic [11:0] dllp_seq,
  output logic [11:0] next_rcv_seq
);

  typedef enum logic {IDLE, SEND} state_e;

  localparam logic [CNT_W-1:0] LAT_LIMIT  = CNT_W'(ACK_LAT - 1);
  localparam logic [CNT_W-1:0] COAL_LIMIT = CNT_W'(ACK_COALESCE);
  localparam logic [11:0]      DUP_WINDOW = 12'd2048;

  state_e           state_q;
  logic [11:0]      next_rcv_seq_q;
  logic [11:0]      dllp_seq_q;
  logic [1:0]       dllp_ack_nack_q;
  logic             dllp_valid_q;
  logic             accept_q;
  logic             discard_q;
  logic             nak_sched_q;
  logic             nak_pending_q;
  logic             ack_pending_q;
  logic             ack_force_q;
  logic [CNT_W-1:0] coal_cnt_q;
  logic [CNT_W-1:0] coal_cnt_d;
  logic [CNT_W-1:0] lat_cnt_q;
  logic [CNT_W-1:0] lat_cnt_d;

  logic [11:0] seq_dist;
  logic [11:0] last_rcv_seq;
  logic        in_order;
  logic        duplicate;
  logic        bad_tlp;
  logic        nak_load;
  logic        ack_load;

  // Distance behind NEXT_RCV_SEQ; up to half the sequence space counts as already seen.
  assign seq_dist     = next_rcv_seq_q - tlp_seq;
  assign last_rcv_seq = next_rcv_seq_q - 12'd1;
  assign in_order     = tlp_done && lcrc_ok && (seq_dist == 12'd0);
  assign duplicate    = tlp_done && lcrc_ok && (seq_dist != 12'd0) && (seq_dist <= DUP_WINDOW);
  assign bad_tlp      = tlp_done && !in_order && !duplicate;

  assign nak_load = (state_q == IDLE) && nak_pending_q;
  assign ack_load = (state_q == IDLE) && !nak_pending_q && ack_pending_q &&
                    (ack_force_q || (coal_cnt_q >= COAL_LIMIT) || (lat_cnt_q >= LAT_LIMIT));

  // A load clears the counters first; a TLP accepted in the same cycle still counts.
  always_comb begin
    coal_cnt_d = coal_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    if (nak_load || ack_load) begin
      coal_cnt_d = '0;
      lat_cnt_d  = '0;
    end else if ((state_q == IDLE) && ack_pending_q) begin
      lat_cnt_d = lat_cnt_q + CNT_W'(1);
    end
    if (in_order && (coal_cnt_d != '1)) begin
      coal_cnt_d = coal_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      next_rcv_seq_q  <= 12'd0;
      dllp_seq_q      <= 12'hFFF;
      dllp_ack_nack_q <= 2'b00;
      dllp_valid_q    <= 1'b0;
      accept_q        <= 1'b0;
      discard_q       <= 1'b0;
      nak_sched_q     <= 1'b0;
      nak_pending_q   <= 1'b0;
      ack_pending_q   <= 1'b0;
      ack_force_q     <= 1'b0;
      coal_cnt_q      <= '0;
      lat_cnt_q       <= '0;
    end else begin
      accept_q   <= in_order;
      discard_q  <= duplicate || bad_tlp;
      coal_cnt_q <= coal_cnt_d;
      lat_cnt_q  <= lat_cnt_d;

      case (state_q)
        IDLE: begin
          if (nak_load) begin
            dllp_valid_q    <= 1'b1;
            dllp_ack_nack_q <= 2'b10;
            dllp_seq_q      <= last_rcv_seq;
            nak_pending_q   <= 1'b0;
            ack_pending_q   <= 1'b0;
            ack_force_q     <= 1'b0;
            state_q         <= SEND;
          end else if (ack_load) begin
            dllp_valid_q    <= 1'b1;
            dllp_ack_nack_q <= 2'b01;
            dllp_seq_q      <= last_rcv_seq;
            ack_pending_q   <= 1'b0;
            ack_force_q     <= 1'b0;
            state_q         <= SEND;
          end
        end
        SEND: begin
          if (dllp_ready) begin
            dllp_valid_q    <= 1'b0;
            dllp_ack_nack_q <= 2'b00;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Flag sets come after the load clears so a same-cycle TLP is never lost.
      if (in_order) begin
        next_rcv_seq_q <= next_rcv_seq_q + 12'd1;
        nak_sched_q    <= 1'b0;
        ack_pending_q  <= 1'b1;
      end
      if (duplicate) begin
        ack_pending_q <= 1'b1;
        ack_force_q   <= 1'b1;
      end
      if (bad_tlp && !nak_sched_q) begin
        nak_pending_q <= 1'b1;
        nak_sched_q   <= 1'b1;
      end
    end
  end

  assign tlp_accept    = accept_q;
  assign tlp_discard   = discard_q;
  assign dllp_valid    = dllp_valid_q;
  assign dllp_ack_nack = dllp_ack_nack_q;
  assign dllp_seq      = dllp_seq_q;
  assign next_rcv_seq  = next_rcv_seq_q;

endmodule

// File: tb/tb_ack_nak_gen.sv
// Directed bench for ack_nak_gen: coalescing, latency timer, NAK scheduling,
// duplicates, back-pressure, reset abort and sequence wrap.
module tb_ack_nak_gen;

  logic        clk;
  logic        rst;
  logic        tlp_done;
  logic [11:0] tlp_seq;
  logic        lcrc_ok;
  logic        tlp_accept;
  logic        tlp_discard;
  logic        dllp_valid;
  logic        dllp_ready;
  logic [1:0]  dllp_ack_nack;
  logic [11:0] dllp_seq;
  logic [11:0] next_rcv_seq;

  int testsRun;
  int testsFailed;

  ack_nak_gen dut (
    .clk           (clk),
    .rst           (rst),
    .tlp_done      (tlp_done),
    .tlp_seq       (tlp_seq),
    .lcrc_ok       (lcrc_ok),
    .tlp_accept    (tlp_accept),
    .tlp_discard   (tlp_discard),
    .dllp_valid    (dllp_valid),
    .dllp_ready    (dllp_ready),
    .dllp_ack_nack (dllp_ack_nack),
    .dllp_seq      (dllp_seq),
    .next_rcv_seq  (next_rcv_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic applyStimulus(input logic done, input logic [11:0] seq, input logic ok);
    tlp_done = done;
    tlp_seq  = seq;
    lcrc_ok  = ok;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 12'd0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  task automatic waitValid(input int maxCycles, output int cycles);
    cycles = 0;
    while (dllp_valid !== 1'b1 && cycles < maxCycles) begin
      idle();
      cycles++;
    end
    checkOutput("dllpValidSeen", 32'(dllp_valid), 1);
  endtask

  initial begin
    int c;
    int extra;
    int unstable;
    int acceptCount;

    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    dllp_ready  = 1'b1;
    tlp_done    = 1'b0;
    tlp_seq     = 12'd0;
    lcrc_ok     = 1'b0;
    idle();
    idle();
    rst = 1'b0;

    checkOutput("rstAccept",   32'(tlp_accept), 0);
    checkOutput("rstDiscard",  32'(tlp_discard), 0);
    checkOutput("rstValid",    32'(dllp_valid), 0);
    checkOutput("rstAckNack",  32'(dllp_ack_nack), 0);
    checkOutput("rstDllpSeq",  32'(dllp_seq), 32'hFFF);
    checkOutput("rstNextSeq",  32'(next_rcv_seq), 0);

    // Four in-order TLPs reach the coalesce limit
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 12'(i), 1'b1);
      checkOutput("coalAccept", 32'(tlp_accept), 1);
    end
    checkOutput("coalNoEarlyAck", 32'(dllp_valid), 0);
    checkOutput("coalNextSeq", 32'(next_rcv_seq), 4);
    idle();
    checkOutput("coalValid", 32'(dllp_valid), 1);
    checkOutput("coalKind",  32'(dllp_ack_nack), 1);
    checkOutput("coalSeq",   32'(dllp_seq), 3);
    idle();
    checkOutput("coalDone",     32'(dllp_valid), 0);
    checkOutput("coalKindNone", 32'(dllp_ack_nack), 0);

    // Single TLP released only by the latency timer, twice to show the timer restarts
    doReset();
    applyStimulus(1'b1, 12'd0, 1'b1);
    waitValid(200, c);
    checkOutput("latCycles", 32'(c), 64);
    checkOutput("latKind",   32'(dllp_ack_nack), 1);
    checkOutput("latSeq",    32'(dllp_seq), 0);
    idle();
    applyStimulus(1'b1, 12'd1, 1'b1);
    waitValid(200, c);
    checkOutput("latCycles2", 32'(c), 64);
    checkOutput("latSeq2",    32'(dllp_seq), 1);
    idle();

    // NAK scheduling: bring NEXT_RCV_SEQ to 5 first
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 12'(i), 1'b1);
    waitValid(5, c);
    checkOutput("preAckSeq3", 32'(dllp_seq), 3);
    idle();
    waitValid(200, c);
    checkOutput("preAckKind", 32'(dllp_ack_nack), 1);
    checkOutput("preAckSeq4", 32'(dllp_seq), 4);
    idle();
    applyStimulus(1'b1, 12'd7, 1'b1);
    checkOutput("aheadDiscard", 32'(tlp_discard), 1);
    checkOutput("aheadAccept",  32'(tlp_accept), 0);
    applyStimulus(1'b1, 12'd8, 1'b0);
    checkOutput("badDiscard", 32'(tlp_discard), 1);
    checkOutput("nakValid",   32'(dllp_valid), 1);
    checkOutput("nakKind",    32'(dllp_ack_nack), 2);
    checkOutput("nakSeq",     32'(dllp_seq), 4);
    idle();
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (dllp_valid === 1'b1) extra++;
    end
    checkOutput("singleNak", 32'(extra), 0);
    checkOutput("nakNextSeq", 32'(next_rcv_seq), 5);
    applyStimulus(1'b1, 12'd5, 1'b1);
    checkOutput("retryAccept", 32'(tlp_accept), 1);
    applyStimulus(1'b1, 12'd9, 1'b0);
    checkOutput("bad2Discard", 32'(tlp_discard), 1);
    waitValid(5, c);
    checkOutput("nak2Cycles", 32'(c), 1);
    checkOutput("nak2Kind",   32'(dllp_ack_nack), 2);
    checkOutput("nak2Seq",    32'(dllp_seq), 5);
    idle();

    // Duplicate forces an immediate ACK
    for (int i = 6; i < 10; i++) applyStimulus(1'b1, 12'(i), 1'b1);
    idle();
    waitValid(5, c);
    checkOutput("ack9Kind", 32'(dllp_ack_nack), 1);
    checkOutput("ack9Seq",  32'(dllp_seq), 9);
    idle();
    applyStimulus(1'b1, 12'd9, 1'b1);
    checkOutput("dupDiscard", 32'(tlp_discard), 1);
    checkOutput("dupAccept",  32'(tlp_accept), 0);
    waitValid(5, c);
    checkOutput("dupCycles", 32'(c), 1);
    checkOutput("dupKind",   32'(dllp_ack_nack), 1);
    checkOutput("dupSeq",    32'(dllp_seq), 9);
    idle();
    checkOutput("dupNextSeq", 32'(next_rcv_seq), 10);

    // Back-pressure: NAK held stable while a good TLP arrives
    dllp_ready = 1'b0;
    applyStimulus(1'b1, 12'd3, 1'b0);
    checkOutput("stallDiscard", 32'(tlp_discard), 1);
    waitValid(5, c);
    checkOutput("stallKind", 32'(dllp_ack_nack), 2);
    checkOutput("stallSeq",  32'(dllp_seq), 9);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        applyStimulus(1'b1, 12'd10, 1'b1);
        checkOutput("stallAccept", 32'(tlp_accept), 1);
      end else begin
        idle();
      end
      if (!(dllp_valid === 1'b1 && dllp_ack_nack === 2'b10 && dllp_seq === 12'd9)) unstable++;
    end
    checkOutput("stallStable", 32'(unstable), 0);
    dllp_ready = 1'b1;
    idle();
    checkOutput("stallReleased", 32'(dllp_valid), 0);
    waitValid(200, c);
    checkOutput("postStallKind", 32'(dllp_ack_nack), 1);
    checkOutput("postStallSeq",  32'(dllp_seq), 10);
    idle();
    checkOutput("postStallNext", 32'(next_rcv_seq), 11);

    // Reset aborts a pending request
    dllp_ready = 1'b0;
    applyStimulus(1'b1, 12'd0, 1'b0);
    waitValid(5, c);
    checkOutput("abortKind", 32'(dllp_ack_nack), 2);
    checkOutput("abortSeq",  32'(dllp_seq), 10);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkOutput("abortValid",   32'(dllp_valid), 0);
    checkOutput("abortAckNack", 32'(dllp_ack_nack), 0);
    checkOutput("abortDllpSeq", 32'(dllp_seq), 32'hFFF);
    checkOutput("abortNextSeq", 32'(next_rcv_seq), 0);
    dllp_ready = 1'b1;
    applyStimulus(1'b1, 12'd0, 1'b1);
    checkOutput("abortSeq0Accept", 32'(tlp_accept), 1);

    // Sequence wrap at 4095
    doReset();
    acceptCount = 0;
    for (int i = 0; i < 4095; i++) begin
      applyStimulus(1'b1, 12'(i), 1'b1);
      if (tlp_accept === 1'b1) acceptCount++;
    end
    checkOutput("wrapAcceptCount", 32'(acceptCount), 4095);
    checkOutput("wrapNextSeq", 32'(next_rcv_seq), 32'hFFF);
    for (int i = 0; i < 150; i++) idle();
    checkOutput("wrapDrained", 32'(dllp_valid), 0);
    applyStimulus(1'b1, 12'hFFF, 1'b1);
    checkOutput("wrapAccept", 32'(tlp_accept), 1);
    checkOutput("wrapNextZero", 32'(next_rcv_seq), 0);
    waitValid(200, c);
    checkOutput("wrapAckKind", 32'(dllp_ack_nack), 1);
    checkOutput("wrapAckSeq",  32'(dllp_seq), 32'hFFF);
    idle();
    applyStimulus(1'b1, 12'd0, 1'b1);
    checkOutput("wrapSeq0Accept", 32'(tlp_accept), 1);
    checkOutput("wrapNextOne", 32'(next_rcv_seq), 1);
    waitValid(200, c);
    checkOutput("wrapAck0Seq", 32'(dllp_seq), 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
